// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared types and constants for the CPU / memory subsystem.
//                Holds the memory-arbiter state and owner encodings together
//                with the instruction field constants.
//                Instruction word = {op_code[3:0], mem_op[1:0], left[4:0], right[4:0]}
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

    // Arbiter ownership phases: core running, loader writing, loader cool-down
    typedef enum logic [1:0] {
        RUN  = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } arb_state_t;

    // Which CPU port a pending read belongs to
    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } mem_owner_t;

    // Instruction field widths
    localparam int OP_CODE_W = 4;
    localparam int MEM_OP_W  = 2;
    localparam int REG_W     = 5;

    // Opcodes
    localparam logic [OP_CODE_W-1:0] OP_NOP = 4'h0;
    localparam logic [OP_CODE_W-1:0] OP_ADD = 4'h1;
    localparam logic [OP_CODE_W-1:0] OP_SUB = 4'h2;
    localparam logic [OP_CODE_W-1:0] OP_MOV = 4'h3;
    localparam logic [OP_CODE_W-1:0] OP_JMP = 4'h4;
    localparam logic [OP_CODE_W-1:0] OP_MEM = 4'h5;

    // Memory operation selector used with OP_MEM
    localparam logic [MEM_OP_W-1:0] MEM_NONE = 2'b00;
    localparam logic [MEM_OP_W-1:0] MEM_LD   = 2'b01;
    localparam logic [MEM_OP_W-1:0] MEM_ST   = 2'b10;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-way round-robin arbiter. req[0] is the fetch port,
//                req[1] the data port. When both request, the one not
//                granted last wins; priority moves only on an actual grant.
//                After reset the fetch port is favoured.
//  Ports       : clk   in   clock
//                rstn  in   asynchronous active-low reset
//                en    in   allow priority update this cycle
//                req   in   [1:0] requests
//                gnt   out  [1:0] one-hot-or-zero grant (combinational)
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter2
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // Port that wins the next tie
    mem_owner_t prio;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (prio == OWN_DATA) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prio <= OWN_FETCH;
        end else if (en && (gnt != 2'b00)) begin
            // Hand the tie to whoever was not just served
            prio <= gnt[0] ? OWN_DATA : OWN_FETCH;
        end
    end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-port memory between the external loader,
//                the CPU fetch port and the CPU data port. The loader has
//                absolute priority and freezes the core via cpu_hold; fetch
//                and data are round-robin arbitrated while the core runs.
//  Ports       : clk, rstn                     clock, async active-low reset
//                ld_req/ld_addr/ld_wdata/ld_gnt loader write port
//                if_req/if_addr/if_gnt/if_rvalid/if_rdata   fetch port
//                dm_req/dm_we/dm_addr/dm_wdata/dm_gnt/dm_rvalid/dm_rdata
//                                               data port
//                mem_en/mem_we/mem_addr/mem_wdata/mem_rdata memory side
//                cpu_hold                       core stall (registered)
//  Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_SIZE   = 5,
    parameter int DATA_SIZE   = 16,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 ld_req,
    input  logic [ADDR_SIZE-1:0] ld_addr,
    input  logic [DATA_SIZE-1:0] ld_wdata,
    output logic                 ld_gnt,
    input  logic                 if_req,
    input  logic [ADDR_SIZE-1:0] if_addr,
    output logic                 if_gnt,
    output logic                 if_rvalid,
    output logic [DATA_SIZE-1:0] if_rdata,
    input  logic                 dm_req,
    input  logic                 dm_we,
    input  logic [ADDR_SIZE-1:0] dm_addr,
    input  logic [DATA_SIZE-1:0] dm_wdata,
    output logic                 dm_gnt,
    output logic                 dm_rvalid,
    output logic [DATA_SIZE-1:0] dm_rdata,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [DATA_SIZE-1:0] mem_wdata,
    input  logic [DATA_SIZE-1:0] mem_rdata,
    output logic                 cpu_hold
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_CYCLES);

    arb_state_t       state;
    logic [CNT_W-1:0] hold_cnt;
    logic             tag_valid;
    mem_owner_t       tag_owner;

    logic             arb_en;
    logic [1:0]       rr_gnt;
    logic             read_gnt;

    // CPU ports compete only while running and the loader is quiet; a loader
    // request in RUN costs one idle cycle while ownership switches to LOAD.
    assign arb_en   = (state == RUN) && !ld_req;
    assign ld_gnt   = (state == LOAD) && ld_req;
    assign if_gnt   = rr_gnt[0];
    assign dm_gnt   = rr_gnt[1];
    assign read_gnt = if_gnt || (dm_gnt && !dm_we);

    rr_arbiter2 u_rr (
        .clk  (clk),
        .rstn (rstn),
        .en   (arb_en),
        .req  ({dm_req, if_req} & {2{arb_en}}),
        .gnt  (rr_gnt)
    );

    // Ownership FSM; cpu_hold is registered so it is low exactly in RUN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= HOLD;
            hold_cnt <= HOLD_INIT;
            cpu_hold <= 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (ld_req) begin
                        state    <= LOAD;
                        cpu_hold <= 1'b1;
                    end
                end
                LOAD: begin
                    if (!ld_req) begin
                        state    <= HOLD;
                        hold_cnt <= HOLD_INIT;
                    end
                end
                HOLD: begin
                    if (ld_req) begin
                        state <= LOAD;
                    end else if (hold_cnt <= CNT_W'(1)) begin
                        state    <= RUN;
                        cpu_hold <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state    <= HOLD;
                    hold_cnt <= HOLD_INIT;
                    cpu_hold <= 1'b1;
                end
            endcase
        end
    end

    // Read-return tag: independent of FSM so an in-flight read survives LOAD
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tag_valid <= 1'b0;
            tag_owner <= OWN_FETCH;
        end else begin
            tag_valid <= read_gnt;
            if (read_gnt) begin
                tag_owner <= if_gnt ? OWN_FETCH : OWN_DATA;
            end
        end
    end

    assign if_rvalid = tag_valid && (tag_owner == OWN_FETCH);
    assign dm_rvalid = tag_valid && (tag_owner == OWN_DATA);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign dm_rdata  = dm_rvalid ? mem_rdata : '0;

    // Memory side mirrors whichever requester holds the grant this cycle
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (ld_gnt) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
        end else if (if_gnt) begin
            mem_en    = 1'b1;
            mem_addr  = if_addr;
        end else if (dm_gnt) begin
            mem_en    = 1'b1;
            mem_we    = dm_we;
            mem_addr  = dm_addr;
            mem_wdata = dm_we ? dm_wdata : '0;
        end
    end

    // Requesters must keep the request stable until it is granted
    a_if_stable: assert property (@(posedge clk) disable iff (!rstn)
        (if_req && !if_gnt) |=> (!if_req || $stable(if_addr)));
    a_dm_stable: assert property (@(posedge clk) disable iff (!rstn)
        (dm_req && !dm_gnt) |=> (!dm_req || $stable({dm_we, dm_addr, dm_wdata})));
    a_one_gnt: assert property (@(posedge clk) disable iff (!rstn)
        $onehot0({ld_gnt, if_gnt, dm_gnt}));

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter. A cycle-level
//                reference model of the arbitration rules runs alongside the
//                DUT and is compared every cycle; directed sequences add
//                hand-computed literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int AW = 5;
    localparam int DW = 16;
    localparam int HOLD_CYCLES = 2;

    localparam int M_RUN  = 0;
    localparam int M_LOAD = 1;
    localparam int M_HOLD = 2;

    logic          clk = 1'b0;
    logic          rstn;
    logic          ld_req, ld_gnt;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          if_req, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata, dm_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          cpu_hold;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_SIZE   (AW),
        .DATA_SIZE   (DW),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .ld_req    (ld_req),
        .ld_addr   (ld_addr),
        .ld_wdata  (ld_wdata),
        .ld_gnt    (ld_gnt),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_gnt    (dm_gnt),
        .dm_rvalid (dm_rvalid),
        .dm_rdata  (dm_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .cpu_hold  (cpu_hold)
    );

    // Memory array with registered read data
    logic [DW-1:0] mem [32];
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        mem_rdata = '0;
    end
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model + per-cycle compare ----------------
    int            m_mode, m_left, m_last, m_pend;
    logic [DW-1:0] m_pdata;
    logic [DW-1:0] shadow [32];

    initial begin
        bit            e_ld, e_if, e_dm, e_en, e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        for (int i = 0; i < 32; i++) shadow[i] = '0;
        m_mode = M_HOLD; m_left = HOLD_CYCLES; m_last = 1; m_pend = 0; m_pdata = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                chk("reset_outs", {ld_gnt, if_gnt, dm_gnt, if_rvalid, dm_rvalid,
                                   mem_en, mem_we, cpu_hold}, 8'b0000_0001);
                chk("reset_mem_bus", {mem_addr, mem_wdata}, '0);
                m_mode = M_HOLD; m_left = HOLD_CYCLES; m_last = 1; m_pend = 0;
            end else begin
                e_ld = (m_mode == M_LOAD) && ld_req;
                e_if = 1'b0;
                e_dm = 1'b0;
                if (m_mode == M_RUN && !ld_req) begin
                    if (if_req && dm_req) begin
                        if (m_last == 1) e_if = 1'b1;
                        else             e_dm = 1'b1;
                    end else begin
                        e_if = if_req;
                        e_dm = dm_req;
                    end
                end
                e_en   = e_ld || e_if || e_dm;
                e_we   = e_ld || (e_dm && dm_we);
                e_addr = e_ld ? ld_addr : (e_if ? if_addr : dm_addr);
                e_wd   = e_ld ? ld_wdata : dm_wdata;

                chk("m_ld_gnt", ld_gnt, e_ld);
                chk("m_if_gnt", if_gnt, e_if);
                chk("m_dm_gnt", dm_gnt, e_dm);
                chk("m_cpu_hold", cpu_hold, m_mode != M_RUN);
                chk("m_if_rvalid", if_rvalid, m_pend == 1);
                chk("m_dm_rvalid", dm_rvalid, m_pend == 2);
                if (m_pend == 1) chk("m_if_rdata", if_rdata, m_pdata);
                if (m_pend == 2) chk("m_dm_rdata", dm_rdata, m_pdata);
                chk("m_mem_en", mem_en, e_en);
                chk("m_mem_we", mem_we, e_we);
                if (e_en) chk("m_mem_addr", mem_addr, e_addr);
                if (e_we) chk("m_mem_wdata", mem_wdata, e_wd);

                // Advance to the state after the coming clock edge
                m_pend = 0;
                if (e_if) begin m_pend = 1; m_pdata = shadow[if_addr]; end
                if (e_dm && !dm_we) begin m_pend = 2; m_pdata = shadow[dm_addr]; end
                if (e_ld) shadow[ld_addr] = ld_wdata;
                if (e_dm && dm_we) shadow[dm_addr] = dm_wdata;
                if (e_if) m_last = 0;
                if (e_dm) m_last = 1;
                case (m_mode)
                    M_RUN:  if (ld_req) m_mode = M_LOAD;
                    M_LOAD: if (!ld_req) begin m_mode = M_HOLD; m_left = HOLD_CYCLES; end
                    default: begin
                        if (ld_req) m_mode = M_LOAD;
                        else begin
                            m_left--;
                            if (m_left == 0) m_mode = M_RUN;
                        end
                    end
                endcase
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_run();
        int n = 0;
        while (cpu_hold && n < 20) begin cyc(); #1; n++; end
        chk("wait_run_timeout", cpu_hold, 1'b0);
    endtask

    task automatic port_req(input bit dport, input bit we, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, input logic [DW-1:0] exp,
                            input string nm);
        int n = 0;
        if (dport) begin dm_req = 1; dm_we = we; dm_addr = a; dm_wdata = wd; end
        else       begin if_req = 1; if_addr = a; end
        #1;
        while (!(dport ? dm_gnt : if_gnt) && n < 20) begin cyc(); #1; n++; end
        chk({nm, "_gnt"}, dport ? dm_gnt : if_gnt, 1'b1);
        cyc();
        if_req = 0; dm_req = 0; dm_we = 0;
        #1;
        if (dport && we) begin
            chk({nm, "_no_rvalid"}, {if_rvalid, dm_rvalid}, 2'b00);
        end else if (dport) begin
            chk({nm, "_rvalid"}, dm_rvalid, 1'b1);
            chk({nm, "_rdata"}, dm_rdata, exp);
        end else begin
            chk({nm, "_rvalid"}, if_rvalid, 1'b1);
            chk({nm, "_rdata"}, if_rdata, exp);
        end
    endtask

    initial begin
        int n;
        rstn = 1; ld_req = 0; ld_addr = '0; ld_wdata = '0;
        if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
        #2 rstn = 0;
        #1 chk("t1_reset_hold", {cpu_hold, ld_gnt, if_gnt, dm_gnt}, 4'b1000);
        repeat (3) cyc();

        // 1: release, cpu_hold high for two cycles, then low
        rstn = 1;
        #1 chk("t1_hold_c0", cpu_hold, 1'b1);
        cyc(); #1 chk("t1_hold_c1", cpu_hold, 1'b1);
        cyc(); #1 chk("t1_hold_c2", cpu_hold, 1'b0);

        // 2: loader writes 0x2110@0, 0x3210@1, 0x0707@7; then fetch addr 0
        ld_req = 1; ld_addr = 5'd0; ld_wdata = 16'h2110;
        #1 chk("t2_switch_no_gnt", ld_gnt, 1'b0);
        cyc(); #1 chk("t2_ld0", {ld_gnt, mem_we, cpu_hold}, 3'b111);
        cyc(); ld_addr = 5'd1; ld_wdata = 16'h3210;
        #1 chk("t2_ld1", {ld_gnt, mem_we, cpu_hold}, 3'b111);
        cyc(); ld_addr = 5'd7; ld_wdata = 16'h0707;
        cyc(); ld_req = 0;
        wait_run();
        port_req(0, 0, 5'd0, '0, 16'h2110, "t2_fetch0");
        cyc();

        // 4: store 0xABCD@7 then load it back
        port_req(1, 1, 5'd7, 16'hABCD, '0, "t4_st7");
        port_req(1, 0, 5'd7, '0, 16'hABCD, "t4_ld7");
        cyc();

        // 3: both ports request for 4 cycles -> F,D,F,D
        if_req = 1; if_addr = 5'd1;
        dm_req = 1; dm_we = 0; dm_addr = 5'd7;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t3_alt", {if_gnt, dm_gnt}, (k % 2 == 0) ? 2'b10 : 2'b01);
            if (k % 2 == 1) chk("t3_if_ret", {if_rvalid, if_rdata}, {1'b1, 16'h3210});
            if (k == 2)     chk("t3_dm_ret", {dm_rvalid, dm_rdata}, {1'b1, 16'hABCD});
            cyc();
        end
        if_req = 0; dm_req = 0;
        #1 chk("t3_dm_last", {dm_rvalid, dm_rdata}, {1'b1, 16'hABCD});
        cyc();

        // 5: loader arrives right after a fetch grant
        if_req = 1; if_addr = 5'd0;
        #1 chk("t5_fetch_gnt", if_gnt, 1'b1);
        cyc();
        if_req = 0; ld_req = 1; ld_addr = 5'd9; ld_wdata = 16'h5555;
        #1 chk("t5_inflight", {if_rvalid, if_rdata, ld_gnt}, {1'b1, 16'h2110, 1'b0});
        cyc(); #1 chk("t5_load", {ld_gnt, cpu_hold}, 2'b11);
        cyc();
        ld_req = 0; if_req = 1; if_addr = 5'd9;
        #1;
        n = 0;
        while (!if_gnt && n < 20) begin cyc(); #1; n++; end
        chk("t5_fetch_delay", n, 3);
        cyc(); if_req = 0;
        #1 chk("t5_fetch9", {if_rvalid, if_rdata}, {1'b1, 16'h5555});
        cyc();

        // 6: async reset during back-to-back fetches
        if_req = 1; if_addr = 5'd1;
        cyc(); cyc();
        #2 rstn = 0;
        #1 chk("t6_async_drop", {if_rvalid, if_gnt, mem_en, cpu_hold}, 4'b0001);
        if_req = 0;
        cyc(); cyc();
        rstn = 1;
        #1 chk("t6_post_release", {if_rvalid, dm_rvalid, cpu_hold}, 3'b001);
        wait_run();
        port_req(0, 0, 5'd1, '0, 16'h3210, "t6_fetch1");
        repeat (3) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire
